// File: rtl/rs_encode_stream_if.sv
// Stream bundle for rs_encode_stream.
//  s_* : message symbols into the encoder (valid/ready, last marks codeword end)
//  m_* : codeword symbols out of the encoder (message, then parity; last on final parity)
// master drives the message stream and sinks the codeword; slave is the encoder.
interface rs_encode_stream_if #(
    parameter int unsigned SYM_W = 8
) ();
    logic             s_valid_i;
    logic             s_ready_o;
    logic [SYM_W-1:0] s_data_i;
    logic             s_last_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [SYM_W-1:0] m_data_o;
    logic             m_parity_o;
    logic             m_last_o;

    modport master (
        output s_valid_i, s_data_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_parity_o, m_last_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_parity_o, m_last_o
    );
endinterface

// File: rtl/rs_encode_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^SYM_W).
// Message symbols pass through a single output register; after the last one (s_last_i or the
// K-th symbol) the NPAR parity symbols held in the generator LFSR are shifted out.
// Ports:
//  clk_i, rst_i (async, active high), clr_i (sync abort back to the reset state)
//  bus        : slave side of rs_encode_stream_if (message in, codeword out)
//  busy_o     : codeword in progress (first message accept .. final parity handshake)
//  overlen_o  : one-cycle pulse after the K-th symbol was accepted without s_last_i
module rs_encode_stream #(
    parameter int unsigned SYM_W     = 8,
    parameter int unsigned K         = 42,
    parameter int unsigned NPAR      = 8,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int unsigned FCR       = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    rs_encode_stream_if.slave   bus,
    output logic                busy_o,
    output logic                overlen_o
);

    localparam int unsigned      CntMax  = (K > NPAR) ? K : NPAR;
    localparam int unsigned      CntW    = $clog2(CntMax + 1);
    localparam logic [SYM_W-1:0] PolyLow = SYM_W'(PRIM_POLY);
    localparam logic [CntW-1:0]  MsgLast = CntW'(K - 1);
    localparam logic [CntW-1:0]  ParLast = CntW'(NPAR - 1);

    // Shift-and-add multiply, reducing by the primitive polynomial on every carry-out.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(SYM_W); i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[SYM_W-1] ? ((sh << 1) ^ PolyLow) : (sh << 1);
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^(FCR+i)); monic, so only the low NPAR coefficients are kept.
    function automatic logic [NPAR-1:0][SYM_W-1:0] gen_poly();
        logic [NPAR:0][SYM_W-1:0] g;
        logic [SYM_W-1:0]         root;
        g    = '0;
        g[0] = SYM_W'(1);
        root = SYM_W'(1);
        for (int k = 0; k < int'(FCR); k++) root = gf_mul(root, SYM_W'(2));
        for (int i = 0; i < int'(NPAR); i++) begin
            for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, SYM_W'(2));
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][SYM_W-1:0] Gen = gen_poly();

    typedef enum logic [0:0] {StData, StParity} state_e;

    state_e                   state_q, state_d;
    logic [NPAR-1:0][SYM_W-1:0] par_q, par_d, par_fb, par_sh;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [SYM_W-1:0]         data_q, data_d;
    logic                     parity_q, parity_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     overlen_q, overlen_d;
    logic                     s_ready;
    logic [SYM_W-1:0]         fb;

    always_comb begin
        state_d   = state_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        parity_d  = parity_q;
        last_d    = last_q;
        busy_d    = busy_q;
        overlen_d = 1'b0;
        s_ready   = 1'b0;

        fb        = bus.s_data_i ^ par_q[NPAR-1];
        par_fb[0] = gf_mul(fb, Gen[0]);
        for (int i = 1; i < int'(NPAR); i++) par_fb[i] = par_q[i-1] ^ gf_mul(fb, Gen[i]);
        par_sh = {par_q[NPAR-2:0], {SYM_W{1'b0}}};

        unique case (state_q)
            StData: begin
                s_ready = !valid_q || bus.m_ready_i;
                if (valid_q && bus.m_ready_i) valid_d = 1'b0;
                if (bus.s_valid_i && s_ready) begin
                    valid_d  = 1'b1;
                    data_d   = bus.s_data_i;
                    parity_d = 1'b0;
                    last_d   = 1'b0;
                    par_d    = par_fb;
                    busy_d   = 1'b1;
                    if (bus.s_last_i || (cnt_q == MsgLast)) begin
                        state_d   = StParity;
                        cnt_d     = '0;
                        overlen_d = !bus.s_last_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (valid_q && last_q) begin
                    // Final parity is parked; the codeword ends on its handshake.
                    if (bus.m_ready_i) begin
                        state_d = StData;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (!valid_q || bus.m_ready_i) begin
                    valid_d  = 1'b1;
                    data_d   = par_q[NPAR-1];
                    parity_d = 1'b1;
                    last_d   = (cnt_q == ParLast);
                    par_d    = par_sh;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = StData;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StData;
            par_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overlen_q <= 1'b0;
        end else if (clr_i) begin
            state_q   <= StData;
            par_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overlen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            overlen_q <= overlen_d;
        end
    end

    assign bus.s_ready_o  = s_ready;
    assign bus.m_valid_o  = valid_q;
    assign bus.m_data_o   = data_q;
    assign bus.m_parity_o = parity_q;
    assign bus.m_last_o   = last_q;
    assign busy_o         = busy_q;
    assign overlen_o      = overlen_q;

endmodule

// File: tb/tb_rs_encode_stream.sv
module tb_rs_encode_stream;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy, overlen, busy_s, overlen_s;

    rs_encode_stream_if #(.SYM_W(8)) bus ();
    rs_encode_stream_if #(.SYM_W(8)) bus_s ();

    rs_encode_stream dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .bus      (bus),
        .busy_o   (busy),
        .overlen_o(overlen)
    );

    rs_encode_stream #(.SYM_W(8), .K(4), .NPAR(2), .PRIM_POLY('h11D), .FCR(0)) dut_s (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .bus      (bus_s),
        .busy_o   (busy_s),
        .overlen_o(overlen_s)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ovl_cnt = 0;
    int         par_seen = 0;
    bit         rand_ready = 1'b0;
    beat_t      exp_q[$];
    beat_t      obs_q[$];
    int         obs_t[$];
    beat_t      obs_s_q[$];
    beat_t      rec_b;
    logic [7:0] msg[$];
    logic [7:0] gen[0:8];
    logic [7:0] gpar[0:7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Observed-beat capture; all checking happens in the test tasks.
    always @(negedge clk) begin
        if (bus.m_valid_o && bus.m_ready_i) begin
            rec_b.d = bus.m_data_o;
            rec_b.p = bus.m_parity_o;
            rec_b.l = bus.m_last_o;
            obs_q.push_back(rec_b);
            obs_t.push_back(cyc);
            if (bus.m_parity_o) par_seen = par_seen + 1;
        end
        if (overlen) ovl_cnt = ovl_cnt + 1;
        if (bus_s.m_valid_o && bus_s.m_ready_i) begin
            rec_b.d = bus_s.m_data_o;
            rec_b.p = bus_s.m_parity_o;
            rec_b.l = bus_s.m_last_o;
            obs_s_q.push_back(rec_b);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            r = r[7] ? ((r << 1) ^ 8'h1D) : (r << 1);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    task automatic build_gen();
        logic [7:0] root;
        for (int j = 0; j <= 8; j++) gen[j] = 8'h00;
        gen[0] = 8'h01;
        root   = 8'h01;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], root);
            gen[0] = gmul(gen[0], root);
            root   = gmul(root, 8'h02);
        end
    endtask

    // Remainder of m(x)*x^8 / g(x) by long division; gpar[0] is the highest-order term.
    task automatic golden();
        logic [7:0] c[$];
        logic [7:0] coef;
        int         len;
        c   = msg;
        len = msg.size();
        for (int j = 0; j < 8; j++) c.push_back(8'h00);
        for (int i = 0; i < len; i++) begin
            coef = c[i];
            for (int j = 1; j <= 8; j++) c[i+j] = c[i+j] ^ gmul(coef, gen[8-j]);
        end
        for (int j = 0; j < 8; j++) gpar[j] = c[len+j];
    endtask

    task automatic push_cw();
        for (int i = 0; i < msg.size(); i++) exp_q.push_back('{d: msg[i], p: 1'b0, l: 1'b0});
        golden();
        for (int j = 0; j < 8; j++) exp_q.push_back('{d: gpar[j], p: 1'b1, l: (j == 7)});
    endtask

    task automatic make_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic flush();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic send(input bit with_last, output bit ok);
        bit acc;
        int n;
        ok = 1'b1;
        for (int i = 0; i < msg.size(); i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = msg[i];
            bus.s_last_i  = with_last && (i == msg.size() - 1);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 500) begin
                @(negedge clk);
                acc = bus.s_ready_o;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) ok = 1'b0;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        total++; if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid_o); end
        total++; if (bus.m_data_o !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%h exp=00", bus.m_data_o); end
        total++; if (bus.m_parity_o !== 1'b0) begin bad++; $display("FAIL rst_m_parity got=%b exp=0", bus.m_parity_o); end
        total++; if (bus.m_last_o !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (overlen !== 1'b0) begin bad++; $display("FAIL rst_overlen got=%b exp=0", overlen); end
        total++; if (bus.s_ready_o !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready_o); end
    endtask

    task automatic test_small_code();
        beat_t e[3];
        beat_t o;
        e[0] = '{d: 8'h01, p: 1'b0, l: 1'b0};
        e[1] = '{d: 8'h03, p: 1'b1, l: 1'b0};
        e[2] = '{d: 8'h02, p: 1'b1, l: 1'b1};
        obs_s_q.delete();
        bus_s.s_valid_i = 1'b1;
        bus_s.s_data_i  = 8'h01;
        bus_s.s_last_i  = 1'b1;
        @(posedge clk);
        #1;
        bus_s.s_valid_i = 1'b0;
        bus_s.s_last_i  = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (obs_s_q.size() != 3) begin
            bad++; $display("FAIL t1_count got=%0d exp=3", obs_s_q.size());
        end
        for (int i = 0; i < 3 && obs_s_q.size() > 0; i++) begin
            o = obs_s_q.pop_front();
            total++;
            if (o !== e[i]) begin
                bad++; $display("FAIL t1_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, o.d, o.p, o.l, e[i].d, e[i].p, e[i].l);
            end
        end
        total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b exp=0", busy_s); end
    endtask

    task automatic test_zeros();
        bit    ok;
        beat_t e, o;
        int    i, span;
        flush();
        ovl_cnt = 0;
        msg.delete();
        for (int k = 0; k < 42; k++) msg.push_back(8'h00);
        push_cw();
        send(1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_send got=timeout exp=accept"); end
        wait_obs(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_wait got=%0d beats exp=50", obs_q.size()); end
        span = (obs_t.size() >= 50) ? (obs_t[49] - obs_t[0]) : -1;
        total++; if (span != 49) begin bad++; $display("FAIL t2_gapless got=%0d cycles exp=49", span); end
        i = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL t2_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, o.d, o.p, o.l, e.d, e.p, e.l); end
            i++;
        end
        total++; if (ovl_cnt != 0) begin bad++; $display("FAIL t2_overlen got=%0d exp=0", ovl_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy got=%b exp=0", busy); end
    endtask

    task automatic test_overlen();
        bit         ok;
        beat_t      e, o;
        int         i;
        logic [7:0] extra;
        flush();
        ovl_cnt = 0;
        make_msg(42);
        push_cw();
        extra = 8'($urandom);
        exp_q.push_back('{d: extra, p: 1'b0, l: 1'b0});
        msg.push_back(extra);
        send(1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_send got=timeout exp=accept"); end
        wait_obs(51, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_wait got=%0d beats exp=51", obs_q.size()); end
        i = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL t3_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, o.d, o.p, o.l, e.d, e.p, e.l); end
            i++;
        end
        total++; if (ovl_cnt != 1) begin bad++; $display("FAIL t3_overlen got=%0d pulses exp=1", ovl_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t3_busy_open got=%b exp=1", busy); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_busy_clr got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        bit         ok;
        beat_t      e, o;
        int         i, n_exp, len0;
        logic [7:0] root, s;
        flush();
        rand_ready = 1'b1;
        len0 = 0;
        for (int m = 0; m < 4; m++) begin
            make_msg((m == 0) ? 42 : int'($urandom_range(1, 42)));
            if (m == 0) len0 = msg.size();
            push_cw();
            send(1'b1, ok);
            total++; if (!ok) begin bad++; $display("FAIL t4_send%0d got=timeout exp=accept", m); end
        end
        n_exp = exp_q.size();
        wait_obs(n_exp, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_wait got=%0d beats exp=%0d", obs_q.size(), n_exp); end
        // The first received codeword must vanish at every generator root.
        if (obs_q.size() >= len0 + 8) begin
            root = 8'h01;
            for (int r = 0; r < 8; r++) begin
                s = 8'h00;
                for (int k = 0; k < len0 + 8; k++) s = gmul(s, root) ^ obs_q[k].d;
                total++;
                if (s !== 8'h00) begin bad++; $display("FAIL t4_syndrome%0d got=%h exp=00", r, s); end
                root = gmul(root, 8'h02);
            end
        end
        i = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL t4_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, o.d, o.p, o.l, e.d, e.p, e.l); end
            i++;
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_clr();
        bit    ok;
        beat_t e, o;
        int    i, n;
        flush();
        par_seen = 0;
        make_msg(42);
        send(1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_send got=timeout exp=accept"); end
        n = 0;
        while (par_seen < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (par_seen < 3) begin bad++; $display("FAIL t5_parity_wait got=%0d exp=3", par_seen); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        total++; if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL t5_m_valid got=%b exp=0", bus.m_valid_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%b exp=0", busy); end
        flush();
        make_msg(20);
        push_cw();
        send(1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_send2 got=timeout exp=accept"); end
        wait_obs(28, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_wait got=%0d beats exp=28", obs_q.size()); end
        i = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL t5_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, o.d, o.p, o.l, e.d, e.p, e.l); end
            i++;
        end
    endtask

    task automatic run_par(output logic [63:0] p, output bit ok);
        bit ok2;
        flush();
        send(1'b1, ok);
        wait_obs(50, ok2);
        ok = ok && ok2;
        p = '0;
        if (obs_q.size() >= 50) for (int j = 0; j < 8; j++) p[63-8*j -: 8] = obs_q[42+j].d;
    endtask

    task automatic test_linearity();
        bit          ok;
        logic [7:0]  ma[$];
        logic [7:0]  mb[$];
        logic [63:0] pa, pb, pab, gold;
        make_msg(42);
        ma = msg;
        golden();
        for (int j = 0; j < 8; j++) gold[63-8*j -: 8] = gpar[j];
        run_par(pa, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_run_a got=timeout exp=50 beats"); end
        total++; if (pa !== gold) begin bad++; $display("FAIL t6_par_a got=%h exp=%h", pa, gold); end
        make_msg(42);
        mb = msg;
        run_par(pb, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_run_b got=timeout exp=50 beats"); end
        msg.delete();
        for (int k = 0; k < 42; k++) msg.push_back(ma[k] ^ mb[k]);
        run_par(pab, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_run_ab got=timeout exp=50 beats"); end
        total++; if (pab !== (pa ^ pb)) begin bad++; $display("FAIL t6_linear got=%h exp=%h", pab, pa ^ pb); end

        // Asynchronous reset in the middle of a message.
        flush();
        make_msg(10);
        send(1'b0, ok);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_busy_pre got=%b exp=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL t6_rst_m_valid got=%b exp=0", bus.m_valid_o); end
        total++; if (bus.m_data_o !== 8'h00) begin bad++; $display("FAIL t6_rst_m_data got=%h exp=00", bus.m_data_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_rst_busy got=%b exp=0", busy); end
        total++; if ({bus.m_parity_o, bus.m_last_o, overlen} !== 3'b000) begin
            bad++; $display("FAIL t6_rst_flags got=%b exp=000", {bus.m_parity_o, bus.m_last_o, overlen});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        make_msg(42);
        golden();
        for (int j = 0; j < 8; j++) gold[63-8*j -: 8] = gpar[j];
        run_par(pa, ok);
        total++; if (pa !== gold) begin bad++; $display("FAIL t6_after_rst got=%h exp=%h", pa, gold); end
    endtask

    initial begin
        bus.s_valid_i   = 1'b0;
        bus.s_data_i    = 8'h00;
        bus.s_last_i    = 1'b0;
        bus.m_ready_i   = 1'b1;
        bus_s.s_valid_i = 1'b0;
        bus_s.s_data_i  = 8'h00;
        bus_s.s_last_i  = 1'b0;
        bus_s.m_ready_i = 1'b1;
        build_gen();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_small_code();
        test_zeros();
        test_overlen();
        test_backpressure();
        test_clr();
        test_linearity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
